fetch_queue: RTL

Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register. It owns the architectural fetch PC, issues in-order word requests to a pipelined instruction memory, and buffers returned instructions in a small FIFO. It presents `{pc, instr}` pairs to decode through a valid/ready handshake, so decode can stall without losing fetched words. On a taken-branch redirect from execute, it flushes all queued and in-flight fetches and restarts at the target.

---
 rtl/fetch_queue.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: owns the fetch PC, issues in-order word fetches to a pipelined imem and buffers {pc, instr}.
// Latency: a response shows on out_* one cycle after it arrives (same cycle with FETCH_QUEUE_BYPASS_EN).
// Backpressure: out_ready low fills the FIFO; issue is held while count + inflight reaches DEPTH, so nothing is lost.
//
// Ports:
//   clk, rst              clock and asynchronous active-low reset
//   imem_req_*            word fetch request (valid/ready); addr is fetch_pc
//   imem_rsp_*            in-order response words, any latency >= 1, no backpressure
//   redirect_valid/_pc    taken branch from execute; flushes queued and in-flight fetches
//   out_valid/_pc/_instr  head instruction presented to decode, popped when out_ready is high
// Optional: define FETCH_QUEUE_BYPASS_EN to forward a response straight to out_* when the FIFO is empty.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        out_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc;

  // Instruction FIFO
  logic [31:0]   fifo_pc    [DEPTH];
  logic [31:0]   fifo_instr [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  // In-flight bookkeeping. inflight counts every outstanding request, stale
  // ones included; discard says how many of the oldest are stale.
  logic [CW-1:0] inflight;
  logic [CW-1:0] discard;

  // PC tags of the live (non-stale) outstanding requests, oldest first.
  logic [31:0]   tag_pc [DEPTH];
  logic [AW-1:0] tag_rd;
  logic [AW-1:0] tag_wr;

  logic [CW:0]   occupancy;
  logic          req_fire;
  logic          rsp_take;
  logic          rsp_keep;
  logic          fifo_has;
  logic          fifo_push;
  logic          fifo_pop;
  logic          bypass_fire;

  assign occupancy = {1'b0, count} + {1'b0, inflight};

  // Gating with rst makes the request drop the instant reset asserts.
  assign imem_req_valid = rst && !redirect_valid && (occupancy < DEPTH_C);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding (e.g. from before a reset) is ignored.
  assign rsp_take = imem_rsp_valid && (inflight != '0);
  assign rsp_keep = rsp_take && !redirect_valid && (discard == '0);

  assign fifo_has = (count != '0);
  assign fifo_pop = fifo_has && out_ready;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass_vld;
  assign bypass_vld  = rsp_keep && !fifo_has;
  assign bypass_fire = bypass_vld && out_ready;
  assign out_valid   = fifo_has || bypass_vld;
  assign out_pc      = fifo_has ? fifo_pc[rd_ptr]
                     : (bypass_vld ? tag_pc[tag_rd] : 32'h0);
  assign out_instr   = fifo_has ? fifo_instr[rd_ptr]
                     : (bypass_vld ? imem_rsp_data : 32'h0);
`else
  assign bypass_fire = 1'b0;
  assign out_valid   = fifo_has;
  assign out_pc      = fifo_has ? fifo_pc[rd_ptr]    : 32'h0;
  assign out_instr   = fifo_has ? fifo_instr[rd_ptr] : 32'h0;
`endif

  // A forwarded-and-consumed response never touches the FIFO.
  assign fifo_push = rsp_keep && !bypass_fire;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      discard  <= '0;
      tag_rd   <= '0;
      tag_wr   <= '0;
    end else begin
      // req_fire is already low in a redirect cycle, so this holds for both paths.
      case ({req_fire, rsp_take})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: ;
      endcase

      if (redirect_valid) begin
        fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
        // Every outstanding request is now stale, including any already
        // being discarded, so the new discard is the whole in-flight count
        // less the response dropped in this very cycle.
        discard  <= inflight - CW'(rsp_take);
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        tag_rd   <= '0;
        tag_wr   <= '0;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + 32'd4;
          tag_wr   <= tag_wr + AW'(1);
        end
        if (rsp_take && (discard != '0)) begin
          discard <= discard - CW'(1);
        end
        // Stale responses have no tag (the tag queue was cleared), so only
        // kept responses pop one.
        if (rsp_keep) begin
          tag_rd <= tag_rd + AW'(1);
        end
        if (fifo_push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (fifo_pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        case ({fifo_push, fifo_pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: ;
        endcase
      end
    end
  end

  // Storage arrays need no reset: nothing reads them until written.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      tag_pc[tag_wr] <= fetch_pc;
    end
    if (fifo_push) begin
      fifo_pc[wr_ptr]    <= tag_pc[tag_rd];
      fifo_instr[wr_ptr] <= imem_rsp_data;
    end
  end

endmodule
